// File: rtl/speaker_mixer.sv
// Mixes the bass and melody square waves with per-channel volume and a fading master gain.
// The result drives one registered PWM audio pin.
module speaker_mixer #(
  parameter int PWM_BITS = 9,
  parameter int FADE_DIV = 65536
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_speaker_b,
  input  logic                i_speaker_m,
  input  logic [3:0]          i_vol_b,
  input  logic [3:0]          i_vol_m,
  input  logic                i_mute,
  input  logic                i_fade_req,
  input  logic                i_resume,
  output logic                o_audio_out,
  output logic [PWM_BITS-1:0] o_level,
  output logic                o_fade_done
);

  localparam int PRE_W  = $clog2(FADE_DIV);
  localparam int PROD_W = (PWM_BITS > 9) ? PWM_BITS : 9;
  localparam logic [PROD_W-1:0]   DUTY_MAX = PROD_W'((64'd1 << PWM_BITS) - 64'd1);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_FADING = 2'd1,
    ST_SILENT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_gain;
  logic [3:0]          w_gain_next;
  logic [PRE_W-1:0]    r_prescaler;
  logic [PRE_W-1:0]    w_pre_next;
  logic                r_fade_done;
  logic                w_fade_done_next;
  logic                r_sb;
  logic                r_sm;
  logic [PWM_BITS-1:0] r_duty_next;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_level;
  logic                r_audio_out;
  logic [4:0]          w_sum;
  logic [8:0]          w_prod;
  logic [PROD_W-1:0]   w_prod_ext;
  logic [PWM_BITS-1:0] w_duty;

  // Mixer datapath: the 0..450 product only clips when the PWM word is narrower than 9 bits.
  assign w_sum      = {1'b0, (r_sb ? i_vol_b : 4'd0)} + {1'b0, (r_sm ? i_vol_m : 4'd0)};
  assign w_prod     = 9'(w_sum) * 9'(r_gain);
  assign w_prod_ext = PROD_W'(w_prod);
  assign w_duty     = (w_prod_ext > DUTY_MAX) ? DUTY_MAX[PWM_BITS-1:0] : w_prod_ext[PWM_BITS-1:0];

  // Fade next-state logic; resume overrides everything, including a same-cycle fade_req.
  always_comb begin
    w_state_next = r_state;
    w_gain_next  = r_gain;
    w_pre_next   = r_prescaler;
    if (i_resume) begin
      w_state_next = ST_PLAY;
      w_gain_next  = 4'd15;
      w_pre_next   = '0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          w_gain_next = 4'd15;
          w_pre_next  = '0;
          if (i_fade_req) begin
            w_state_next = ST_FADING;
          end else begin
            w_state_next = ST_PLAY;
          end
        end
        ST_FADING: begin
          if (r_prescaler == PRE_LAST) begin
            w_pre_next  = '0;
            w_gain_next = r_gain - 4'd1;
            if (r_gain == 4'd1) begin
              w_state_next = ST_SILENT;
            end else begin
              w_state_next = ST_FADING;
            end
          end else begin
            w_pre_next = r_prescaler + PRE_ONE;
          end
        end
        ST_SILENT: begin
          w_gain_next = 4'd0;
          w_pre_next  = '0;
        end
        default: begin
          w_state_next = ST_PLAY;
          w_gain_next  = 4'd15;
          w_pre_next   = '0;
        end
      endcase
    end
    w_fade_done_next = (r_state == ST_SILENT) && !i_resume;
  end

  // Fade state, gain and prescaler registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state     <= ST_PLAY;
      r_gain      <= 4'd15;
      r_prescaler <= '0;
      r_fade_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_gain      <= w_gain_next;
      r_prescaler <= w_pre_next;
      r_fade_done <= w_fade_done_next;
    end
  end

  // Input registers and the duty pipeline stage.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_sb        <= 1'b0;
      r_sm        <= 1'b0;
      r_duty_next <= '0;
    end else begin
      r_sb        <= i_speaker_b;
      r_sm        <= i_speaker_m;
      r_duty_next <= w_duty;
    end
  end

  // PWM: the duty is latched only at the end of a period so a period never changes mid-way.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_pwm_cnt   <= '0;
      r_level     <= '0;
      r_audio_out <= 1'b0;
    end else begin
      r_pwm_cnt   <= r_pwm_cnt + CNT_ONE;
      r_audio_out <= !i_mute && (r_pwm_cnt < r_level);
      if (r_pwm_cnt == CNT_MAX) begin
        r_level <= r_duty_next;
      end else begin
        r_level <= r_level;
      end
    end
  end

  assign o_audio_out = r_audio_out;
  assign o_level     = r_level;
  assign o_fade_done = r_fade_done;

endmodule

// File: doc/speaker_mixer.md
Name: speaker_mixer

Overview:
- Downstream stage of the music player. Consumes the two 1-bit square-wave tone outputs (bass `speaker_b`, melody `speaker_m`).
- Mixes them with per-channel volume and a master gain, then drives a single PWM audio pin.
- Master gain is controlled by a fade-out state machine, so the game can fade music at stage end and restore it on resume.

Parameters:
- PWM_BITS, 9: width of PWM counter and duty word. Period = 2^PWM_BITS clocks.
- FADE_DIV, 65536: clocks per master-gain decrement step during fade. Legal range ≥ 2.

Ports:
- clock  in  1: system clock.
- reset_n  in  1: synchronous, active-low reset.
- speaker_b  in  1: bass tone square wave.
- speaker_m  in  1: melody tone square wave.
- vol_b  in  4: bass volume, 0..15.
- vol_m  in  4: melody volume, 0..15.
- mute  in  1: level; forces audio silent.
- fade_req  in  1: 1-cycle pulse; starts fade-out.
- resume  in  1: 1-cycle pulse; restores full gain.
- audio_out  out  1: registered PWM output.
- level  out  PWM_BITS: currently latched duty (debug/verification).
- fade_done  out  1: high while in SILENT.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-low, sampled on the rising edge of `clock`.
- Reset values: audio_out=0, level=0, fade_done=0, pwm_cnt=0, gain=15, state=PLAY, prescaler=0, input registers=0, product register=0.
- Reset asserted mid-operation returns every register to its reset value at that edge.
- Stage 1: `speaker_b` and `speaker_m` are registered once. Volumes are not registered.
- Stage 2: sum = (sb_r ? vol_b : 0) + (sm_r ? vol_m : 0), 5 bits, range 0..30.
  - prod = sum × gain, 9 bits, range 0..450.
  - Registered as duty_next = min(prod, 2^PWM_BITS − 1). This saturates only when PWM_BITS < 9.
- PWM:
  - pwm_cnt increments every clock and wraps from 2^PWM_BITS − 1 to 0.
  - On the cycle pwm_cnt == max, level <= duty_next. level never changes mid-period.
  - audio_out <= (mute == 0) && (pwm_cnt < level), registered.
  - level=0 gives constant low.
  - Mute takes effect on the first edge where it is sampled high and releases the same way. Mute does not affect the FSM, gain or level.
- Fade FSM, states PLAY, FADING, SILENT:
  - PLAY: gain=15. fade_req → FADING, prescaler cleared.
  - FADING: prescaler counts 0..FADE_DIV−1. On terminal count gain decrements by 1 and prescaler wraps to 0. When gain becomes 0 → SILENT.
  - SILENT: gain=0, fade_done=1 (registered, asserted the cycle after the state change).
  - resume in any state → PLAY, gain=15, prescaler=0, fade_done=0 on the next edge.
  - fade_req in FADING or SILENT: ignored.
  - fade_req and resume in the same cycle: resume wins.
- Latency, input edge to duty_next: 2 cycles (input register, product register). Plus up to 2^PWM_BITS cycles until the next period latch.
- Full fade duration: 15 × FADE_DIV clocks from fade_req to SILENT.
- Gain changes also reach level only at period boundaries.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles with speaker_b=speaker_m=1, vol_b=vol_m=15 → audio_out=0, level=0, fade_done=0 throughout. After release, first period latch gives level=450.
2. Single channel: speaker_b=1, speaker_m=0, vol_b=10, gain 15 → level=150 after the next wrap. Exactly 150 high cycles per 512-cycle period, starting at pwm_cnt=0.
3. Both channels: vol_b=15, vol_m=15, both inputs high → level=450, 450/512 high. Change vol_m to 0 mid-period → level stays 450 until wrap, then 225.
4. Fade with FADE_DIV=4: pulse fade_req → gain reaches 0 after 60 cycles. fade_done rises 1 cycle after the SILENT entry. level=0 after the following wrap. Extra fade_req pulses are ignored. Pulse resume → fade_done=0 next cycle, gain=15.
5. Mute: assert mute at pwm_cnt=20 with level=150 → audio_out=0 from the next edge. Deassert at pwm_cnt=100 → audio_out=1 next edge. level is unchanged throughout.
6. Collisions: fade_req and resume in the same cycle during FADING → PLAY, gain=15. Reset asserted mid-fade (gain=7) → gain=15, PLAY, audio_out=0.
